// File: rtl/ahb_bus_arbiter_if.sv
// rtl/ahb_bus_arbiter_if.sv - request/grant bundle between the AHB masters and the bus arbiter
//
// Purpose : carries the per-master request/lock lines, the current owner's
//           transfer controls, and the arbiter's registered grant outputs.
// Modports: slave  - arbiter side (samples requests, drives grant/owner/lock)
//           master - master/bus side (drives requests, samples grant/owner/lock)
// Signals : HBUSREQ[N], HLOCK[N], HTRANS[2], HBURST[3], HREADY
//           HGRANT[N], HMASTER[MID_W], HMASTLOCK
interface ahb_bus_arbiter_if #(
   parameter int NO_OF_MASTERS = 2,
   parameter int MID_W         = 1
);
   logic [NO_OF_MASTERS-1:0] HBUSREQ;
   logic [NO_OF_MASTERS-1:0] HLOCK;
   logic [1:0]               HTRANS;
   logic [2:0]               HBURST;
   logic                     HREADY;
   logic [NO_OF_MASTERS-1:0] HGRANT;
   logic [MID_W-1:0]         HMASTER;
   logic                     HMASTLOCK;

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      output HGRANT, HMASTER, HMASTLOCK
   );

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      input  HGRANT, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - burst-aware round-robin AHB bus arbiter
//
// Purpose : shares one AHB address/data bus between NO_OF_MASTERS masters.
//           Fixed-length bursts are never split, INCR bursts are held while
//           the owner keeps requesting, and locked sequences keep the grant.
// Ports   : HCLK   - bus clock, rising edge
//           HRESET - synchronous active-high reset
//           bus    - ahb_bus_arbiter_if.slave
//                    in : HBUSREQ, HLOCK, HTRANS, HBURST, HREADY
//                    out: HGRANT (one-hot), HMASTER, HMASTLOCK (all registered)
module ahb_bus_arbiter #(
   parameter int NO_OF_MASTERS  = 2,
   parameter int DEFAULT_MASTER = 0,
   parameter int MID_W          = 1
) (
   input  logic                HCLK,
   input  logic                HRESET,
   ahb_bus_arbiter_if.slave    bus
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] BR_SINGLE = 3'b000;
   localparam logic [2:0] BR_INCR   = 3'b001;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FIXED = 2'd1;
   localparam logic [1:0] ST_INCR  = 2'd2;

   localparam logic [NO_OF_MASTERS-1:0] DEF_GRANT = NO_OF_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [MID_W-1:0]         DEF_IDX   = MID_W'(DEFAULT_MASTER);

   logic [1:0]               state_q, state_nxt;
   logic [3:0]               beat_cnt_q, beat_cnt_nxt;
   logic [MID_W-1:0]         rr_ptr_q;
   logic [NO_OF_MASTERS-1:0] grant_q;
   logic [MID_W-1:0]         hmaster_q;
   logic                     hmastlock_q;

   logic [MID_W-1:0]         grant_idx;
   logic [MID_W-1:0]         win_idx;
   logic                     any_req;
   logic                     ap_raw;
   logic                     take_ap;
   logic                     owner_req;
   logic [3:0]               fixed_last;
   int                       cand;

   assign bus.HGRANT    = grant_q;
   assign bus.HMASTER   = hmaster_q;
   assign bus.HMASTLOCK = hmastlock_q;

   assign owner_req = bus.HBUSREQ[hmaster_q];

   // Grant is always one-hot, so a plain priority scan recovers its index.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NO_OF_MASTERS; i++) begin
         if (grant_q[i]) grant_idx = MID_W'(i);
      end
   end

   // Round-robin scan starting just after the last winner; the last winner
   // is visited last, so it only re-wins when nobody else is asking.
   always_comb begin
      any_req = 1'b0;
      win_idx = DEF_IDX;
      cand    = 0;
      for (int k = 1; k <= NO_OF_MASTERS; k++) begin
         cand = (int'(rr_ptr_q) + k) % NO_OF_MASTERS;
         if (!any_req && bus.HBUSREQ[cand]) begin
            any_req = 1'b1;
            win_idx = MID_W'(cand);
         end
      end
   end

   // Remaining address beats after the NONSEQ: 4/8/16-beat bursts.
   always_comb begin
      case (bus.HBURST[2:1])
         2'b01:   fixed_last = 4'd3;
         2'b10:   fixed_last = 4'd7;
         2'b11:   fixed_last = 4'd15;
         default: fixed_last = 4'd0;
      endcase
   end

   // Burst tracking of the HMASTER owner. A NONSEQ always (re)starts
   // tracking from its HBURST, whichever state we were in.
   always_comb begin
      state_nxt    = state_q;
      beat_cnt_nxt = beat_cnt_q;
      ap_raw       = 1'b0;
      if (bus.HREADY) begin
         if (bus.HTRANS == TR_NONSEQ) begin
            beat_cnt_nxt = 4'd0;
            if (bus.HBURST == BR_SINGLE) begin
               state_nxt = ST_IDLE;
               ap_raw    = 1'b1;
            end else if (bus.HBURST == BR_INCR) begin
               state_nxt = ST_INCR;
            end else begin
               state_nxt    = ST_FIXED;
               beat_cnt_nxt = fixed_last;
            end
         end else begin
            case (state_q)
               ST_IDLE: ap_raw = 1'b1;
               ST_FIXED: begin
                  if (bus.HTRANS == TR_SEQ) begin
                     if (beat_cnt_q == 4'd1) begin
                        ap_raw       = 1'b1;
                        state_nxt    = ST_IDLE;
                        beat_cnt_nxt = 4'd0;
                     end else begin
                        beat_cnt_nxt = beat_cnt_q - 4'd1;
                     end
                  end else if (bus.HTRANS == TR_IDLE) begin
                     ap_raw       = 1'b1;
                     state_nxt    = ST_IDLE;
                     beat_cnt_nxt = 4'd0;
                  end
               end
               ST_INCR: begin
                  if (!owner_req || bus.HTRANS == TR_IDLE) begin
                     ap_raw    = 1'b1;
                     state_nxt = ST_IDLE;
                  end
               end
               default: begin
                  ap_raw    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            endcase
         end
      end
   end

   // A locked grant suppresses every arbitration point; burst tracking
   // still advances so a fixed burst completes normally after unlock.
   assign take_ap = ap_raw && !bus.HLOCK[grant_idx];

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_IDLE;
         beat_cnt_q  <= 4'd0;
         rr_ptr_q    <= DEF_IDX;
         grant_q     <= DEF_GRANT;
         hmaster_q   <= DEF_IDX;
         hmastlock_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         beat_cnt_q <= beat_cnt_nxt;
         if (bus.HREADY) begin
            hmaster_q   <= grant_idx;
            hmastlock_q <= bus.HLOCK[grant_idx];
         end
         if (take_ap) begin
            if (any_req) begin
               grant_q  <= NO_OF_MASTERS'(1) << win_idx;
               rr_ptr_q <= win_idx;
            end else begin
               grant_q  <= DEF_GRANT;
            end
         end
      end
   end

endmodule
